// File: rtl/picorv32_wb_bridge.sv
// picorv32 native memory interface to Wishbone classic bridge: one registered bus cycle per
// core request, optional split instruction/data buses and a watchdog for hung cycles.
module picorv32_wb_bridge #(
  parameter int unsigned SPLIT_BUS      = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  // picorv32 native interface
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  // primary Wishbone bus
  output logic        core_cyc,
  output logic        core_stb,
  output logic        core_we,
  output logic [3:0]  core_sel,
  output logic [31:0] core_addr,
  output logic [31:0] core_data_out,
  input  logic [31:0] core_data_in,
  input  logic        core_ack,
  // secondary Wishbone bus
  output logic        data_mem_cyc,
  output logic        data_mem_stb,
  output logic        data_mem_we,
  output logic [3:0]  data_mem_sel,
  output logic [31:0] data_mem_addr,
  output logic [31:0] data_mem_data_out,
  input  logic [31:0] data_mem_data_in,
  input  logic        data_mem_ack,
  output logic        timeout_o
);

  localparam int unsigned WdogW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WdogW-1:0] WdogMax = WdogW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] data;
  } wb_req_t;

  state_e           state_q;
  wb_req_t          core_q, dmem_q;
  logic             tgt_dmem_q;
  logic [WdogW-1:0] wdog_q;
  logic             mem_ready_q;
  logic [31:0]      mem_rdata_q;
  logic             timeout_q;

  wb_req_t     req_bus;
  logic        req_dmem;
  logic        bus_ack;
  logic [31:0] bus_din;
  logic        wdog_hit;

  always_comb begin
    req_bus.cyc  = 1'b1;
    req_bus.stb  = 1'b1;
    req_bus.we   = |mem_wstrb;
    req_bus.sel  = (|mem_wstrb) ? mem_wstrb : 4'hF;
    req_bus.addr = mem_addr;
    req_bus.data = mem_wdata;
    req_dmem     = (SPLIT_BUS != 0) && !mem_instr;
    bus_ack      = tgt_dmem_q ? data_mem_ack : core_ack;
    bus_din      = tgt_dmem_q ? data_mem_data_in : core_data_in;
    wdog_hit     = (TIMEOUT_CYCLES != 0) && (wdog_q == WdogMax);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      core_q      <= '0;
      dmem_q      <= '0;
      tgt_dmem_q  <= 1'b0;
      wdog_q      <= '0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      mem_ready_q <= 1'b0;
      timeout_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (mem_valid) begin
            tgt_dmem_q <= req_dmem;
            wdog_q     <= '0;
            if (req_dmem) begin
              dmem_q <= req_bus;
            end else begin
              core_q <= req_bus;
            end
            state_q <= StReq;
          end
        end
        StReq: begin
          // Ack takes priority over a simultaneous watchdog expiry.
          if (bus_ack) begin
            mem_rdata_q <= bus_din;
          end else if (wdog_hit) begin
            mem_rdata_q <= ERR_DATA;
            timeout_q   <= 1'b1;
          end else begin
            wdog_q <= wdog_q + WdogW'(1);
          end
          if (bus_ack || wdog_hit) begin
            core_q      <= '0;
            dmem_q      <= '0;
            mem_ready_q <= mem_valid;
            state_q     <= StResp;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign mem_ready         = mem_ready_q;
  assign mem_rdata         = mem_rdata_q;
  assign timeout_o         = timeout_q;
  assign core_cyc          = core_q.cyc;
  assign core_stb          = core_q.stb;
  assign core_we           = core_q.we;
  assign core_sel          = core_q.sel;
  assign core_addr         = core_q.addr;
  assign core_data_out     = core_q.data;
  assign data_mem_cyc      = dmem_q.cyc;
  assign data_mem_stb      = dmem_q.stb;
  assign data_mem_we       = dmem_q.we;
  assign data_mem_sel      = dmem_q.sel;
  assign data_mem_addr     = dmem_q.addr;
  assign data_mem_data_out = dmem_q.data;

endmodule

// File: tb/tb_picorv32_wb_bridge.sv
// Scoreboard bench for picorv32_wb_bridge built with a split bus and an 8-cycle watchdog.
module tb_picorv32_wb_bridge;

  localparam logic [31:0] ErrData = 32'hDEAD_BEEF;
  localparam int          Tmo     = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mem_valid = 1'b0, mem_instr = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        core_cyc, core_stb, core_we;
  logic [3:0]  core_sel;
  logic [31:0] core_addr, core_data_out;
  logic [31:0] core_data_in = '0;
  logic        core_ack = 1'b0;
  logic        data_mem_cyc, data_mem_stb, data_mem_we;
  logic [3:0]  data_mem_sel;
  logic [31:0] data_mem_addr, data_mem_data_out;
  logic [31:0] data_mem_data_in = '0;
  logic        data_mem_ack = 1'b0;
  logic        timeout_o;

  picorv32_wb_bridge #(
    .SPLIT_BUS     (1),
    .TIMEOUT_CYCLES(Tmo),
    .ERR_DATA      (ErrData)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mem_valid        (mem_valid),
    .mem_instr        (mem_instr),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_wstrb        (mem_wstrb),
    .mem_ready        (mem_ready),
    .mem_rdata        (mem_rdata),
    .core_cyc         (core_cyc),
    .core_stb         (core_stb),
    .core_we          (core_we),
    .core_sel         (core_sel),
    .core_addr        (core_addr),
    .core_data_out    (core_data_out),
    .core_data_in     (core_data_in),
    .core_ack         (core_ack),
    .data_mem_cyc     (data_mem_cyc),
    .data_mem_stb     (data_mem_stb),
    .data_mem_we      (data_mem_we),
    .data_mem_sel     (data_mem_sel),
    .data_mem_addr    (data_mem_addr),
    .data_mem_data_out(data_mem_data_out),
    .data_mem_data_in (data_mem_data_in),
    .data_mem_ack     (data_mem_ack),
    .timeout_o        (timeout_o)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  logic [70:0]  core_bus, dm_bus;
  logic [175:0] all_out;
  assign core_bus = {core_cyc, core_stb, core_we, core_sel, core_addr, core_data_out};
  assign dm_bus   = {data_mem_cyc, data_mem_stb, data_mem_we, data_mem_sel, data_mem_addr,
                     data_mem_data_out};
  assign all_out  = {mem_ready, mem_rdata, core_bus, dm_bus, timeout_o};

  typedef struct {
    logic [31:0] rdata;
    logic        to;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  // One core request with the bench acting as slave on the expected target bus.
  task automatic do_req(input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input int waits, input logic [31:0] sdata,
                        input bit no_ack, output int stb_at);
    int          n, first_c, want_len;
    bit          done;
    logic        tdm;
    logic [70:0] tbus, obus;
    logic [68:0] want_fields;
    exp_t        e, got;
    tdm         = !instr;
    want_fields = {|wstrb, (wstrb != 0) ? wstrb : 4'hF, addr, wdata};
    want_len    = no_ack ? Tmo : waits + 1;
    n = 0; first_c = 0; done = 1'b0; stb_at = -1;
    e.rdata = no_ack ? ErrData : sdata;
    e.to    = no_ack;
    sb.push_back(e);
    mem_valid = 1'b1; mem_instr = instr; mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk); #1;
      core_ack = 1'b0; data_mem_ack = 1'b0;
      core_data_in = 32'h0BAD_F00D; data_mem_data_in = 32'h0BAD_F00D;
      tbus = tdm ? dm_bus : core_bus;
      obus = tdm ? core_bus : dm_bus;
      if (mem_ready) begin
        done = 1'b1;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL scoreboard: mem_ready with no pending request at cycle %0d", cycle);
        end else begin
          got = sb.pop_front();
          checks++;
          if (mem_rdata !== got.rdata) begin
            errors++;
            $display("FAIL rdata: got %h want %h", mem_rdata, got.rdata);
          end
          checks++;
          if (timeout_o !== got.to) begin
            errors++;
            $display("FAIL timeout_pulse: got %b want %b", timeout_o, got.to);
          end
        end
        checks++;
        if (c - first_c != want_len) begin
          errors++;
          $display("FAIL ready_latency: got %0d want %0d cycles after stb", c - first_c, want_len);
        end
        checks++;
        if (n != want_len) begin
          errors++;
          $display("FAIL stb_cycles: got %0d want %0d", n, want_len);
        end
        checks++;
        if (tbus[70] !== 1'b0) begin
          errors++;
          $display("FAIL cyc_drop_in_resp: got %b want 0", tbus[70]);
        end
      end else begin
        checks++;
        if (timeout_o !== 1'b0) begin
          errors++;
          $display("FAIL timeout_idle: got %b want 0 at cycle %0d", timeout_o, cycle);
        end
        if (tbus[70] && tbus[69]) begin
          n++;
          if (n == 1) begin
            first_c = c;
            stb_at  = cycle;
            checks++;
            if (tbus[68:0] !== want_fields) begin
              errors++;
              $display("FAIL bus_fields: got %h want %h", tbus[68:0], want_fields);
            end
          end
          checks++;
          if (obus !== '0) begin
            errors++;
            $display("FAIL other_bus_zero: got %h want 0", obus);
          end
          if (!no_ack && n == waits + 1) begin
            if (tdm) begin
              data_mem_ack = 1'b1; data_mem_data_in = sdata;
            end else begin
              core_ack = 1'b1; core_data_in = sdata;
            end
          end
        end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL ready_wait: got no mem_ready within 40 cycles want one");
    end
  endtask

  task automatic idle(input int n);
    mem_valid = 1'b0; mem_wstrb = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({mem_ready, timeout_o, core_cyc, data_mem_cyc} !== 4'b0) begin
        errors++;
        $display("FAIL idle_quiet: got ready/to/ccyc/dcyc=%b want 0000",
                 {mem_ready, timeout_o, core_cyc, data_mem_cyc});
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_async: got %h want 0", all_out);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_held: got %h want 0", all_out);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_read_zero_wait();
    int s;
    do_req(1'b1, 32'h0000_0100, 32'h0, 4'h0, 0, 32'h1234_5678, 1'b0, s);
    idle(2);
  endtask

  task automatic test_byte_write();
    int s;
    do_req(1'b1, 32'h0000_0203, 32'hAB00_0000, 4'b1000, 3, 32'h55AA_55AA, 1'b0, s);
    idle(2);
  endtask

  task automatic test_split_bus();
    int s;
    do_req(1'b1, 32'h0000_0000, 32'h0, 4'h0, 1, 32'h0000_0013, 1'b0, s);
    idle(1);
    do_req(1'b0, 32'h0000_1000, 32'h0, 4'h0, 2, 32'hFEED_1000, 1'b0, s);
    idle(1);
    do_req(1'b0, 32'h0000_1004, 32'h1122_3344, 4'b0011, 0, 32'h0, 1'b0, s);
    idle(2);
  endtask

  task automatic test_timeout();
    int s;
    do_req(1'b0, 32'h0000_2000, 32'h0, 4'h0, 0, 32'h0, 1'b1, s);
    idle(3);
  endtask

  task automatic test_ack_at_expiry();
    int s;
    do_req(1'b1, 32'h0000_0400, 32'h0, 4'h0, Tmo - 1, 32'hA5A5_0007, 1'b0, s);
    idle(2);
  endtask

  task automatic test_back_to_back();
    int s1, s2, s3;
    do_req(1'b1, 32'h0000_0500, 32'h0, 4'h0, 0, 32'h1111_0001, 1'b0, s1);
    do_req(1'b1, 32'h0000_0504, 32'h0, 4'h0, 0, 32'h2222_0002, 1'b0, s2);
    do_req(1'b1, 32'h0000_0508, 32'h0, 4'h0, 0, 32'h3333_0003, 1'b0, s3);
    idle(2);
    checks++;
    if (s2 - s1 != 3 || s3 - s2 != 3) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d,%0d want 3,3", s2 - s1, s3 - s2);
    end
  endtask

  task automatic test_spurious_ack();
    int s;
    core_ack = 1'b1; data_mem_ack = 1'b1;
    core_data_in = 32'h7777_7777; data_mem_data_in = 32'h7777_7777;
    idle(3);
    core_ack = 1'b0; data_mem_ack = 1'b0;
    checks++;
    if (mem_rdata !== 32'h3333_0003) begin
      errors++;
      $display("FAIL spurious_ack_rdata: got %h want 33330003", mem_rdata);
    end
    do_req(1'b0, 32'h0000_1100, 32'h0, 4'h0, 2, 32'h0102_0304, 1'b0, s);
    idle(2);
  endtask

  task automatic test_reset_mid();
    int s;
    mem_valid = 1'b1; mem_instr = 1'b1; mem_addr = 32'h0000_0300; mem_wstrb = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({core_cyc, core_stb} !== 2'b11) begin
      errors++;
      $display("FAIL mid_req_active: got cyc/stb=%b want 11", {core_cyc, core_stb});
    end
    #2 rst_n = 1'b0;
    mem_valid = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL mid_reset_async: got %h want 0", all_out);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(8);
    do_req(1'b1, 32'h0000_0304, 32'h0, 4'h0, 1, 32'hCAFE_0001, 1'b0, s);
    idle(2);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running want finished");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    test_reset();
    test_read_zero_wait();
    test_byte_write();
    test_split_bus();
    test_timeout();
    test_ack_at_expiry();
    test_back_to_back();
    test_spurious_ack();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
